ssd_scan_driver: RTL and testbench

Output-side counterpart to the push-button input conditioning. It drives a 4-digit, common-anode seven-segment display by time-multiplexing four hex digits. Each digit slot starts with an anti-ghosting blank interval. New display values are applied only at frame boundaries, through a request/acknowledge handshake, so a partially updated frame is never shown. The game logic (score, timer) is the only client.

---
 rtl/ssd_pkg.sv | 24 ++
 rtl/ssd_hex_decoder.sv | 13 +
 rtl/ssd_scan_driver.sv | 145 ++++++++++++++
 tb/tb_ssd_scan_driver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and hex-to-segment decode for the seven-segment
// scan driver.
//   SEG_OFF  - all segments (and dp) dark, active-low
//   AN_OFF   - all anodes off, active-low
//   HEX_SEG  - 16-entry table of active-low {g,f,e,d,c,b,a} patterns
//   hex2seg  - nibble -> 7-bit active-low segment pattern
package ssd_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] AN_OFF  = 4'hF;

   // Packed so that entry n sits at HEX_SEG[n]; listed from F down to 0.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
      return HEX_SEG[nibble];
   endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder: combinational hex digit to active-low segment decoder.
//   hex  in  4  hex digit
//   seg  out 7  active-low {g,f,e,d,c,b,a}
module ssd_hex_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = hex2seg(hex);

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Each digit slot opens with an anti-ghosting blank
// interval. New display data is staged on upd and only moved into the shadow
// (displayed) registers at the frame boundary, so a frame never mixes old and
// new data.
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   upd         in   one-cycle load request
//   digits_in   in   four hex nibbles, [3:0] = digit 0 (rightmost)
//   blank_in    in   per-digit dark request
//   dp_in       in   per-digit decimal point request
//   upd_ack     out  pulse when requested data becomes visible
//   frame_done  out  pulse after the digit-3 slot ends
//   ssd_an      out  active-low anodes, bit i = digit i
//   ssd_seg     out  active-low segments {dp,g,f,e,d,c,b,a}
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int unsigned DIV   = 25000,
   parameter int unsigned BLANK = 1000,
   parameter int unsigned CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        upd,
   input  logic [15:0] digits_in,
   input  logic [3:0]  blank_in,
   input  logic [3:0]  dp_in,
   output logic        upd_ack,
   output logic        frame_done,
   output logic [3:0]  ssd_an,
   output logic [7:0]  ssd_seg
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             pending_q, pending_d;
   logic [15:0]      stg_digits_q, stg_digits_d;
   logic [3:0]       stg_blank_q, stg_blank_d;
   logic [3:0]       stg_dp_q, stg_dp_d;
   logic [15:0]      sh_digits_q, sh_digits_d;
   logic [3:0]       sh_blank_q, sh_blank_d;
   logic [3:0]       sh_dp_q, sh_dp_d;
   logic [3:0]       an_q, an_d;
   logic [7:0]       seg_q, seg_d;
   logic             ack_q, ack_d;
   logic             fd_q, fd_d;

   logic             last_slot;
   logic             boundary;
   logic             blank_phase;
   logic [3:0]       cur_hex;
   logic [6:0]       cur_seg;

   assign cur_hex = sh_digits_q[{idx_q, 2'b00} +: 4];

   ssd_hex_decoder u_dec (
      .hex (cur_hex),
      .seg (cur_seg)
   );

   always_comb begin
      last_slot   = (cnt_q == CNT_W'(DIV - 1));
      boundary    = last_slot && (idx_q == 2'd3);
      blank_phase = (cnt_q < CNT_W'(BLANK));

      cnt_d = last_slot ? '0 : cnt_q + CNT_W'(1);
      idx_d = last_slot ? idx_q + 2'd1 : idx_q;

      stg_digits_d = stg_digits_q;
      stg_blank_d  = stg_blank_q;
      stg_dp_d     = stg_dp_q;
      if (upd) begin
         stg_digits_d = digits_in;
         stg_blank_d  = blank_in;
         stg_dp_d     = dp_in;
      end

      // A request landing on the boundary itself bypasses staging so it is
      // not held back a whole frame.
      sh_digits_d = sh_digits_q;
      sh_blank_d  = sh_blank_q;
      sh_dp_d     = sh_dp_q;
      pending_d   = pending_q;
      if (boundary) begin
         pending_d = 1'b0;
         if (upd) begin
            sh_digits_d = digits_in;
            sh_blank_d  = blank_in;
            sh_dp_d     = dp_in;
         end else if (pending_q) begin
            sh_digits_d = stg_digits_q;
            sh_blank_d  = stg_blank_q;
            sh_dp_d     = stg_dp_q;
         end
      end else if (upd) begin
         pending_d = 1'b1;
      end

      ack_d = boundary && (upd || pending_q);
      fd_d  = boundary;

      an_d  = blank_phase ? AN_OFF : ~(4'b0001 << idx_q);
      seg_d = (blank_phase || sh_blank_q[idx_q]) ? SEG_OFF
                                                 : {~sh_dp_q[idx_q], cur_seg};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         pending_q    <= 1'b0;
         stg_digits_q <= 16'h0000;
         stg_blank_q  <= 4'h0;
         stg_dp_q     <= 4'h0;
         sh_digits_q  <= 16'h0000;
         sh_blank_q   <= 4'hF;
         sh_dp_q      <= 4'h0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         ack_q        <= 1'b0;
         fd_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         stg_digits_q <= stg_digits_d;
         stg_blank_q  <= stg_blank_d;
         stg_dp_q     <= stg_dp_d;
         sh_digits_q  <= sh_digits_d;
         sh_blank_q   <= sh_blank_d;
         sh_dp_q      <= sh_dp_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         ack_q        <= ack_d;
         fd_q         <= fd_d;
      end
   end

   assign ssd_an     = an_q;
   assign ssd_seg    = seg_q;
   assign upd_ack    = ack_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed scenarios plus randomized traffic, checked
// every cycle against a tick-based reference model of the display.
module tb_ssd_scan_driver;

   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        upd = 1'b0;
   logic [15:0] digits_in = 16'h0000;
   logic [3:0]  blank_in  = 4'h0;
   logic [3:0]  dp_in     = 4'h0;
   logic        upd_ack;
   logic        frame_done;
   logic [3:0]  ssd_an;
   logic [7:0]  ssd_seg;

   always #5 clk = ~clk;

   ssd_scan_driver #(.DIV(DIV), .BLANK(BLANK), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .upd        (upd),
      .digits_in  (digits_in),
      .blank_in   (blank_in),
      .dp_in      (dp_in),
      .upd_ack    (upd_ack),
      .frame_done (frame_done),
      .ssd_an     (ssd_an),
      .ssd_seg    (ssd_seg)
   );

   // Active-low g..a patterns for hex 0..F.
   localparam bit [6:0] SEG_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the display position follows directly from the number
   // of clock edges since reset; shown/staged data are plain per-digit arrays.
   int       m_tick;
   bit [3:0] m_dig [4];
   bit       m_blk [4];
   bit       m_dp  [4];
   bit [3:0] s_dig [4];
   bit       s_blk [4];
   bit       s_dp  [4];
   bit       m_pend;
   bit [3:0] e_an;
   bit [7:0] e_seg;
   bit       e_ack, e_fd;

   always @(posedge clk) begin
      int pos, d;
      bit bnd;
      if (rst) begin
         m_tick = 0;
         m_pend = 0;
         for (int i = 0; i < 4; i++) begin
            m_dig[i] = 0; m_blk[i] = 1; m_dp[i] = 0;
            s_dig[i] = 0; s_blk[i] = 0; s_dp[i] = 0;
         end
         e_an = 4'hF; e_seg = 8'hFF; e_ack = 0; e_fd = 0;
      end else begin
         pos   = m_tick % DIV;
         d     = (m_tick / DIV) % 4;
         bnd   = (pos == DIV - 1) && (d == 3);
         e_an  = (pos < BLANK) ? 4'hF : ~(4'b0001 << d);
         e_seg = (pos < BLANK || m_blk[d]) ? 8'hFF : {~m_dp[d], SEG_TAB[m_dig[d]]};
         e_fd  = bnd;
         e_ack = bnd && (m_pend || upd);
         if (upd) begin
            for (int i = 0; i < 4; i++) begin
               s_dig[i] = digits_in[4*i +: 4];
               s_blk[i] = blank_in[i];
               s_dp[i]  = dp_in[i];
            end
         end
         if (bnd) begin
            if (upd || m_pend) begin
               m_dig = s_dig; m_blk = s_blk; m_dp = s_dp;
            end
            m_pend = 0;
         end else if (upd) begin
            m_pend = 1;
         end
         m_tick++;
      end
   end

   int       n_ack, n_fd;
   bit       seen1;
   logic [7:0] cap [4];

   task automatic step();
      @(posedge clk);
      #1;
      check("an", ssd_an, e_an);
      check("seg", ssd_seg, e_seg);
      check("ack", upd_ack, e_ack);
      check("frame_done", frame_done, e_fd);
      check("an_onehot", ($countones(~ssd_an) <= 1), 1);
      if (upd_ack) n_ack++;
      if (frame_done) n_fd++;
      for (int i = 0; i < 4; i++)
         if (ssd_an == ~(4'b0001 << i)) cap[i] = ssd_seg;
      if (ssd_an != 4'hF && ssd_seg[6:0] == 7'h79) seen1 = 1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic upd_pulse(input logic [15:0] dg, input logic [3:0] bl, input logic [3:0] dp);
      digits_in = dg; blank_in = bl; dp_in = dp; upd = 1'b1;
      step();
      upd = 1'b0;
   endtask

   // Advance until the next edge is the frame boundary (bounded).
   task automatic to_boundary();
      int g = 0;
      while (m_tick % FRAME != FRAME - 1 && g < FRAME) begin
         step();
         g++;
      end
      check("boundary_reached", m_tick % FRAME, FRAME - 1);
   endtask

   task automatic clear_cap();
      for (int i = 0; i < 4; i++) cap[i] = 8'h55;
   endtask

   initial begin
      run(2);
      check("rst_an", ssd_an, 4'hF);
      check("rst_seg", ssd_seg, 8'hFF);
      rst = 1'b0;

      // Dark display after reset, frame_done once per 32 cycles, no ack.
      n_ack = 0; n_fd = 0;
      run(40);
      check("idle_fd_cnt", n_fd, 1);
      check("idle_ack_cnt", n_ack, 0);

      // Single mid-frame update.
      run(3);
      upd_pulse(16'h1234, 4'h0, 4'h0);
      to_boundary();
      step();
      check("ack_1234", upd_ack, 1);
      clear_cap();
      run(FRAME);
      check("ack_cnt_1234", n_ack, 1);
      check("d0_seg_4", cap[0], 8'h99);
      check("d3_seg_1", cap[3], 8'hF9);

      // Two requests in one frame: last one wins, single ack.
      n_ack = 0;
      upd_pulse(16'h1111, 4'h0, 4'h0);
      run(3);
      upd_pulse(16'h8888, 4'h0, 4'h1);
      to_boundary();
      step();
      seen1 = 0;
      clear_cap();
      run(FRAME);
      check("ack_cnt_double", n_ack, 1);
      check("d0_seg_8dp", cap[0], 8'h00);
      check("d1_seg_8", cap[1], 8'h80);
      check("no_1111", seen1, 0);

      // Request on the boundary cycle itself.
      to_boundary();
      digits_in = 16'hABCD; blank_in = 4'h0; dp_in = 4'h0; upd = 1'b1;
      step();
      upd = 1'b0;
      check("ack_bnd", upd_ack, 1);
      clear_cap();
      run(FRAME);
      check("bnd_d0_D", cap[0], 8'hA1);
      check("bnd_d1_C", cap[1], 8'hC6);
      check("bnd_d2_b", cap[2], 8'h83);
      check("bnd_d3_A", cap[3], 8'h88);

      // Reset mid-slot with a pending request.
      run(DIV + 4);
      upd_pulse(16'h5555, 4'h0, 4'h0);
      run(1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_an", ssd_an, 4'hF);
      check("rst_mid_seg", ssd_seg, 8'hFF);
      n_ack = 0;
      clear_cap();
      run(2 * FRAME);
      check("rst_no_ack", n_ack, 0);
      check("rst_dark_d0", cap[0], 8'hFF);
      upd_pulse(16'h4321, 4'b1000, 4'h0);
      to_boundary();
      step();
      check("ack_blank", upd_ack, 1);
      clear_cap();
      run(FRAME);
      check("blank_d3", cap[3], 8'hFF);
      check("blank_d0_1", cap[0], 8'hF9);

      // Randomized traffic with occasional reset.
      for (int k = 0; k < 600; k++) begin
         digits_in = 16'($urandom);
         blank_in  = 4'($urandom);
         dp_in     = 4'($urandom);
         upd       = ($urandom_range(0, 11) == 0);
         rst       = ($urandom_range(0, 249) == 0);
         step();
      end
      upd = 1'b0;
      rst = 1'b0;
      run(FRAME);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
